// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running W-bit up-counter: locks onto a +1 (mod 2^W)
// stream and reports wraps, resyncs and violations with wrap/error tallies.
module count_seq_checker #(
  parameter int W            = 3,
  parameter int WRAP_W       = 8,
  parameter int ERR_W        = 4,
  parameter int LOCK_N       = 2,
  parameter int ALLOW_RESYNC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      a,
  input  logic              clr,
  output logic              locked,
  output logic              wrap,
  output logic              resync,
  output logic              err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [W-1:0]     MAX_A     = {W{1'b1}};
  localparam logic [2:0]       LOCK_N_L  = 3'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic             RESYNC_OK = (ALLOW_RESYNC != 0);

  state_t              r_state;
  logic [W-1:0]        r_prev;
  logic                r_have_prev;
  logic [2:0]          r_run;
  logic                r_locked;
  logic                r_wrap;
  logic                r_resync;
  logic                r_err;
  logic [WRAP_W-1:0]   r_wrap_cnt;
  logic [ERR_W-1:0]    r_err_cnt;

  logic [W-1:0]        w_succ;
  logic                w_seq_ok;
  logic                w_is_zero;
  logic [2:0]          w_run_inc;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  assign w_succ    = r_prev + 1'b1;
  assign w_seq_ok  = (a == w_succ);
  assign w_is_zero = (a == '0);
  assign w_run_inc = r_run + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= HUNT;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_wrap      <= 1'b0;
      r_resync    <= 1'b0;
      r_err       <= 1'b0;
      r_wrap_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_wrap   <= 1'b0;
      r_resync <= 1'b0;
      r_err    <= 1'b0;
      if (en) begin
        r_prev <= a;
        if (!r_have_prev) begin
          r_have_prev <= 1'b1;
        end else begin
          case (r_state)
            HUNT: begin
              if (w_seq_ok) begin
                if (w_run_inc == LOCK_N_L) begin
                  r_state  <= LOCK;
                  r_locked <= 1'b1;
                  r_run    <= '0;
                end else begin
                  r_run <= w_run_inc;
                end
              end else begin
                r_run <= '0;
              end
            end
            LOCK: begin
              // The +1 check comes first so MAX->0 is always a wrap, never a resync.
              if (w_seq_ok) begin
                if (r_prev == MAX_A) begin
                  r_wrap     <= 1'b1;
                  r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
              end else if (w_is_zero && RESYNC_OK) begin
                r_resync <= 1'b1;
              end else begin
                r_err     <= 1'b1;
                r_err_cnt <= sat_inc(r_err_cnt);
                r_state   <= HUNT;
                r_locked  <= 1'b0;
                r_run     <= '0;
              end
            end
            default: begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
              r_run    <= '0;
            end
          endcase
        end
      end
      // Clear overrides any same-cycle increment; pulses still fire.
      if (clr) begin
        r_wrap_cnt <= '0;
        r_err_cnt  <= '0;
      end
    end
  end

  assign locked   = r_locked;
  assign wrap     = r_wrap;
  assign resync   = r_resync;
  assign err      = r_err;
  assign wrap_cnt = r_wrap_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: one resync-enabled instance and one
// resync-disabled instance driven by the same count stream.
module tb_count_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] a;
  logic       clr;

  logic       locked, wrap, resync, err;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;
  logic       locked0, wrap0, resync0, err0;
  logic [7:0] wrap_cnt0;
  logic [3:0] err_cnt0;

  int checks   = 0;
  int failures = 0;
  logic [2:0] cur;
  int exp_err;

  count_seq_checker #(.W(3), .WRAP_W(8), .ERR_W(4), .LOCK_N(2), .ALLOW_RESYNC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr),
    .locked(locked), .wrap(wrap), .resync(resync), .err(err),
    .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  count_seq_checker #(.W(3), .WRAP_W(8), .ERR_W(4), .LOCK_N(2), .ALLOW_RESYNC(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr),
    .locked(locked0), .wrap(wrap0), .resync(resync0), .err(err0),
    .wrap_cnt(wrap_cnt0), .err_cnt(err_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [2:0] v, input logic c);
    en  = e;
    a   = v;
    clr = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
    if (e) cur = v;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; a = '0; clr = 1'b0; cur = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if ({wrap, resync, err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {wrap, resync, err}); end
    checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL reset_wrap_cnt got=%0d exp=0", wrap_cnt); end
    checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_lock;
    step(1, 3'd0, 0);
    step(1, 3'd1, 0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", locked); end
    step(1, 3'd2, 0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_at_2 got=%b exp=1", locked); end
    step(1, 3'd3, 0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lock_err got=%b exp=0", err); end
    checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL lock_wrap_cnt got=%0d exp=0", wrap_cnt); end
  endtask

  task automatic test_wrap;
    for (int v = 4; v < 8; v++) begin
      step(1, 3'(v), 0);
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_early a=%0d got=%b exp=0", v, wrap); end
    end
    step(1, 3'd0, 0);
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_pulse got=%b exp=1", wrap); end
    checks++; if (wrap_cnt !== 8'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", wrap_cnt); end
    checks++; if (resync !== 1'b0) begin failures++; $display("FAIL wrap_not_resync got=%b exp=0", resync); end
    step(1, 3'd1, 0);
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap); end
  endtask

  task automatic test_resync;
    step(1, 3'd2, 0);
    step(1, 3'd3, 0);
    step(1, 3'd4, 0);
    step(1, 3'd0, 0);
    checks++; if (resync !== 1'b1) begin failures++; $display("FAIL resync_pulse got=%b exp=1", resync); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL resync_locked got=%b exp=1", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL resync_no_err got=%b exp=0", err); end
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL noresync_err got=%b exp=1", err0); end
    checks++; if (err_cnt0 !== 4'd1) begin failures++; $display("FAIL noresync_err_cnt got=%0d exp=1", err_cnt0); end
    checks++; if (locked0 !== 1'b0) begin failures++; $display("FAIL noresync_unlock got=%b exp=0", locked0); end
    step(1, 3'd1, 0);
    checks++; if (resync !== 1'b0) begin failures++; $display("FAIL resync_one_cycle got=%b exp=0", resync); end
    checks++; if (locked0 !== 1'b0) begin failures++; $display("FAIL noresync_hunt got=%b exp=0", locked0); end
    step(1, 3'd2, 0);
    checks++; if (locked0 !== 1'b1) begin failures++; $display("FAIL noresync_relock got=%b exp=1", locked0); end
    checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL resync_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_error;
    step(1, 3'd3, 0);
    step(1, 3'd6, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL error_pulse got=%b exp=1", err); end
    checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL error_cnt got=%0d exp=1", err_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL error_unlock got=%b exp=0", locked); end
    step(1, 3'd5, 0);
    checks++; if (err !== 1'b0 || err_cnt !== 4'd1) begin failures++; $display("FAIL error_hunt_silent got=%b/%0d exp=0/1", err, err_cnt); end
    exp_err = 1;
  endtask

  task automatic test_saturate;
    logic [2:0] bad;
    for (int i = 0; i < 20; i++) begin
      step(1, cur + 3'd1, 0);
      step(1, cur + 3'd1, 0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sat_relock i=%0d got=%b exp=1", i, locked); end
      bad = cur + 3'd3;
      if (bad == 3'd0) bad = 3'd4;
      step(1, bad, 0);
      exp_err = (exp_err < 15) ? exp_err + 1 : 15;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL sat_err_pulse i=%0d got=%b exp=1", i, err); end
      checks++; if (err_cnt !== 4'(exp_err)) begin failures++; $display("FAIL sat_err_cnt i=%0d got=%0d exp=%0d", i, err_cnt, exp_err); end
    end
    checks++; if (err_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", err_cnt); end
  endtask

  task automatic test_clr;
    step(1, cur + 3'd1, 0);
    step(1, cur + 3'd1, 0);
    while (cur != 3'd7) step(1, cur + 3'd1, 0);
    checks++; if (wrap_cnt !== 8'd1) begin failures++; $display("FAIL clr_pre_wrap_cnt got=%0d exp=1", wrap_cnt); end
    step(1, 3'd0, 1);
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL clr_wrap_pulse got=%b exp=1", wrap); end
    checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL clr_wrap_cnt got=%0d exp=0", wrap_cnt); end
    checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clr_locked got=%b exp=1", locked); end
  endtask

  task automatic test_back_to_back;
    step(1, 3'd1, 0);
    step(1, 3'd2, 0);
    step(0, 3'd6, 0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap_err1 got=%b exp=0", err); end
    step(0, 3'd5, 0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap_err2 got=%b exp=0", err); end
    step(1, 3'd3, 0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap_resume_err got=%b exp=0", err); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_locked got=%b exp=1", locked); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 21; i++) step(1, cur + 3'd1, 0);
    checks++; if (wrap_cnt !== 8'd3) begin failures++; $display("FAIL ar_pre_wrap_cnt got=%0d exp=3", wrap_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ar_pre_locked got=%b exp=1", locked); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL ar_locked got=%b exp=0", locked); end
    checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL ar_wrap_cnt got=%0d exp=0", wrap_cnt); end
    checks++; if (err_cnt0 !== 4'd0) begin failures++; $display("FAIL ar_err_cnt got=%0d exp=0", err_cnt0); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1, 3'd0, 0);
    step(1, 3'd1, 0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL ar_relock_early got=%b exp=0", locked); end
    step(1, 3'd2, 0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ar_relock got=%b exp=1", locked); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_wrap;
    test_resync;
    test_error;
    test_saturate;
    test_clr;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
